mic_spi_scan_ctrl: RTL and testbench
====================================

Name: mic_spi_scan_ctrl

Overview:
- Sequencer that shares one SPI-style capture engine (shared SCK, shared SDO line) between up to N_CH microphone/ADC devices, each on its own chip select.
- Runs round-robin capture frames over the enabled channels: one CS low, a fixed number of SCK cycles, one sample word extracted, then an inter-frame gap.
- Hands each word to the downstream note-recognition / filter logic over a valid/ready interface, tagged with its channel number.
- Sits between the board pins and the audio processing pipeline.

Parameters:
- N_CH, 2: number of devices / chip selects (1..8).
- SCK_HALF, 8: clk cycles per SCK half-period (>=2).
- FRAME_BITS, 32: SCK cycles per frame.
- LEAD_BITS, 1: bits discarded at frame start before the data word.
- DATA_W, 16: output word width. LEAD_BITS+DATA_W <= FRAME_BITS.
- GAP_CYCLES, 64: clk cycles with all CS high between frames (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run the scan; 0 = stop after the current frame.
- ch_mask  in  N_CH  per-channel enable; bit i selects cs_n[i].
- cs_n  out  N_CH  active-low chip selects; at most one is low at a time.
- sck  out  1  serial clock; idles high.
- sdo  in  1  shared serial data from the devices.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  captured sample.
- out_ch  out  max(1,$clog2(N_CH))  channel index of out_data.
- overrun  out  1  one-cycle pulse when a completed word is dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low) takes effect immediately:
  - cs_n all 1, sck=1, out_valid=0, out_data=0, out_ch=0, overrun=0, busy=0.
  - FSM goes to IDLE; the round-robin pointer goes to N_CH-1, so the first channel served is the lowest set mask bit.
- Reset asserted mid-frame aborts the frame. No word is output.
- IDLE:
  - If enable=1 and ch_mask!=0, pick the next channel and go to SETUP.
  - Otherwise stay in IDLE.
- Channel pick:
  - Take the first set bit of ch_mask strictly after the last served channel, wrapping around.
  - ch_mask is sampled only at pick time. Changes mid-frame do not affect the current frame.
- SETUP (SCK_HALF cycles): cs_n[ch]=0, sck=1.
- SHIFT (2*SCK_HALF*FRAME_BITS cycles): each bit is SCK_HALF cycles of sck=0 followed by SCK_HALF cycles of sck=1.
- Sampling:
  - sdo is sampled on the last clk of each low half, i.e. the cycle before the rising SCK edge.
  - It is shifted into a FRAME_BITS-wide register, MSB first.
- DONE (1 cycle):
  - cs_n all 1; sck=1.
  - word = shift[FRAME_BITS-1-LEAD_BITS -: DATA_W]. Defaults give shift[30:15].
  - If out_valid=0, or out_valid=1 with out_ready=1 in this same cycle: load out_data and out_ch; out_valid=1 from the next cycle.
  - Otherwise keep the old word and pulse overrun for this one cycle (new word dropped).
- GAP (GAP_CYCLES cycles): all CS high.
  - At the end, if enable=1 and ch_mask!=0, pick the next channel and go to SETUP.
  - Otherwise go to IDLE.
- enable deasserted during SETUP or SHIFT: the frame completes normally and the word is delivered.
- Output handshake: out_valid falls the cycle after out_valid && out_ready, unless DONE reloads it in that same cycle.
- Frame period (defaults): 8 + 512 + 1 + 64 = 585 clk.
- Single enabled channel: the same channel repeats every frame.
- busy=0 only in IDLE.

Decomposition:
- Package mic_scan_pkg:
  - state enum {IDLE, SETUP, SHIFT, DONE, GAP}.
  - Default parameter constants.
  - Width helper for out_ch.
- Sub-module spi_bit_shifter: owns the SCK half-period counter, the bit counter, sck generation, sample strobe, shift register and frame_done.
- Controller owns the FSM, round-robin pick, CS decode and output register.

Test Plan:
- Single channel, ch_mask=01, device model returns 0x5A5A_0000 MSB-first -> out_data=0xB4B4, out_ch=0, cs_n[1] never low, SCK=32 cycles per frame, frame period 585 clk.
- ch_mask=11, models return 0x1234_8000 (ch0) and 0x7FFF_FFFF (ch1), out_ready=1 -> words alternate: (0x2469, ch0), then (0xFFFF, ch1). Never both CS low.
- out_ready=0 across two frames -> first word held in out_data; overrun pulses exactly 1 cycle in the second frame's DONE; raise out_ready -> held word accepted, out_valid falls the next cycle.
- enable dropped 100 clk into SHIFT -> frame completes, word delivered, GAP runs, then IDLE with busy=0, cs_n all 1, sck=1.
- reset_n pulsed low mid-SHIFT -> cs_n all 1 and sck=1 immediately (asynchronous); no out_valid; after release the scan restarts at the lowest enabled channel.
- ch_mask changed from 01 to 10 during SHIFT -> current ch0 frame finishes and outputs; the next frame selects ch1. ch_mask=0 at pick time -> IDLE.

Source files
------------

// File: rtl/mic_scan_pkg.sv
// mic_scan_pkg: shared state encoding, default parameters and width helper for the mic scan controller
package mic_scan_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

    localparam int DEF_N_CH       = 2;
    localparam int DEF_SCK_HALF   = 8;
    localparam int DEF_FRAME_BITS = 32;
    localparam int DEF_LEAD_BITS  = 1;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_GAP_CYCLES = 64;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mic_spi_scan_ctrl_shifter.sv
// spi_bit_shifter: generates SCK for one frame, samples SDO before each rising edge, flags the last cycle
module spi_bit_shifter
    import mic_scan_pkg::*;
#(
    parameter int SCK_HALF   = DEF_SCK_HALF,
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  sck,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] shift_q
);

    localparam int HW = $clog2(SCK_HALF);
    localparam int BW = $clog2(FRAME_BITS);

    logic          active;
    logic [HW-1:0] hcnt;
    logic [BW-1:0] bcnt;
    logic          half_end;

    assign half_end   = hcnt == HW'(SCK_HALF - 1);
    assign frame_done = active && sck && half_end && bcnt == BW'(FRAME_BITS - 1);

    // half-period timing: low half ends with a sample, high half ends the bit; sck parks high when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            sck     <= 1'b1;
            hcnt    <= '0;
            bcnt    <= '0;
            shift_q <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sck     <= 1'b0;
            hcnt    <= '0;
            bcnt    <= '0;
            shift_q <= '0;
        end else if (active) begin
            if (half_end) begin
                hcnt <= '0;
                if (!sck) begin
                    sck     <= 1'b1;
                    shift_q <= {shift_q[FRAME_BITS-2:0], sdo};
                end else if (bcnt == BW'(FRAME_BITS - 1)) begin
                    active <= 1'b0;
                end else begin
                    sck  <= 1'b0;
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mic_spi_scan_ctrl.sv
// mic_spi_scan_ctrl: round-robin SPI capture sequencer over several chip-selected microphones
module mic_spi_scan_ctrl
    import mic_scan_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int SCK_HALF   = DEF_SCK_HALF,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int LEAD_BITS  = DEF_LEAD_BITS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [N_CH-1:0]         ch_mask,
    output logic [N_CH-1:0]         cs_n,
    output logic                    sck,
    input  logic                    sdo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ch_w(N_CH)-1:0]   out_ch,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CW    = ch_w(N_CH);
    localparam int CMAX  = (GAP_CYCLES > SCK_HALF) ? GAP_CYCLES : SCK_HALF;
    localparam int CNT_W = $clog2(CMAX + 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CW-1:0]           ch;
    logic [CW-1:0]           last_ch;
    logic [CW-1:0]           pick;
    logic                    go;
    logic                    start;
    logic                    frame_done;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [DATA_W-1:0]       word;

    assign go      = enable && |ch_mask;
    assign start   = state == SETUP && cnt == CNT_W'(SCK_HALF - 1);
    assign word    = shift_q[FRAME_BITS-1-LEAD_BITS -: DATA_W];
    assign overrun = state == DONE && out_valid && !out_ready;
    assign busy    = state != IDLE;

    // first set mask bit strictly after the last served channel; scanning downward lets the nearest win
    always_comb begin
        pick = last_ch;
        for (int i = N_CH; i >= 1; i--)
            if (ch_mask[(int'(last_ch) + i) % N_CH]) pick = CW'((int'(last_ch) + i) % N_CH);
    end

    spi_bit_shifter #(
        .SCK_HALF   (SCK_HALF),
        .FRAME_BITS (FRAME_BITS)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sdo        (sdo),
        .sck        (sck),
        .frame_done (frame_done),
        .shift_q    (shift_q)
    );

    // frame sequencing, chip-select decode and the single-entry output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ch        <= '0;
            last_ch   <= CW'(N_CH - 1);
            cs_n      <= '1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state <= SETUP;
                    ch    <= pick;
                    cnt   <= '0;
                    cs_n  <= ~(N_CH'(1) << pick);
                end
                SETUP: if (start) state <= SHIFT;
                       else cnt <= cnt + 1'b1;
                SHIFT: if (frame_done) begin
                    state <= DONE;
                    cs_n  <= '1;
                end
                DONE: begin
                    state   <= GAP;
                    cnt     <= '0;
                    last_ch <= ch;
                    if (!overrun) begin
                        out_valid <= 1'b1;
                        out_data  <= word;
                        out_ch    <= ch;
                    end
                end
                GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt <= '0;
                    if (go) begin
                        state <= SETUP;
                        ch    <= pick;
                        cs_n  <= ~(N_CH'(1) << pick);
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_spi_scan_ctrl.sv
// tb_mic_spi_scan_ctrl: directed self-checking bench with a two-device SPI model
`timescale 1ns/1ps
module tb_mic_spi_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  ch_mask = 2'b00;
    logic [1:0]  cs_n;
    logic        sck;
    logic        sdo;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [0:0]  out_ch;
    logic        overrun;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mic_spi_scan_ctrl #(
        .N_CH(2), .SCK_HALF(8), .FRAME_BITS(32), .LEAD_BITS(1), .DATA_W(16), .GAP_CYCLES(64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .cs_n      (cs_n),
        .sck       (sck),
        .sdo       (sdo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .overrun   (overrun),
        .busy      (busy)
    );

    logic [31:0] pat [2];
    logic [31:0] cur;
    logic        cs_act;
    int          bitn = 0;

    assign cs_act = ~&cs_n;

    always @(posedge cs_act) bitn = 0;
    always @(posedge sck) if (cs_act) bitn = bitn + 1;

    always_comb begin
        cur = !cs_n[0] ? pat[0] : pat[1];
        sdo = (cs_act && bitn < 32) ? cur[31 - bitn] : 1'b0;
    end

    int  both_low = 0;
    int  cs1_low = 0;
    int  ovr_cnt = 0;
    int  sck_rises = 0;
    time t_fall [$];

    always @(negedge clk) begin
        if (!cs_n[0] && !cs_n[1]) both_low++;
        if (!cs_n[1]) cs1_low++;
        if (overrun) ovr_cnt++;
    end
    always @(posedge sck) sck_rises++;
    always @(negedge cs_n[0]) t_fall.push_back($time);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 1);
    endtask

    task automatic wait_cs(input string tag, input int idx, input int budget);
        int k = 0;
        while (cs_n[idx] && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(cs_n[idx]), 0);
    endtask

    task automatic do_reset(input logic [1:0] mask, input logic rdy);
        reset_n = 1'b0;
        tick(2);
        ch_mask = mask;
        out_ready = rdy;
        enable = 1'b1;
        both_low = 0;
        cs1_low = 0;
        ovr_cnt = 0;
        sck_rises = 0;
        t_fall.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        int k;
        pat[0] = 32'h5A5A_0000;
        pat[1] = 32'h7FFF_FFFF;
        tick(2);
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_sck", 32'(sck), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_ch", 32'(out_ch), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);

        do_reset(2'b01, 1'b1);
        wait_valid("t1_w0", 1200);
        check("t1_data0", 32'(out_data), 32'hB4B4);
        check("t1_ch0", 32'(out_ch), 0);
        check("t1_sck_rises", 32'(sck_rises), 32);
        tick(1);
        check("t1_valid_drop", 32'(out_valid), 0);
        wait_valid("t1_w1", 1200);
        check("t1_data1", 32'(out_data), 32'hB4B4);
        check("t1_period", (t_fall.size() >= 2) ? 32'((t_fall[1] - t_fall[0]) / 10) : 32'h0, 585);
        check("t1_cs1_low", 32'(cs1_low), 0);

        pat[0] = 32'h1234_8000;
        do_reset(2'b11, 1'b1);
        wait_valid("t2_w0", 1200);
        check("t2_data0", 32'(out_data), 32'h2469);
        check("t2_ch0", 32'(out_ch), 0);
        tick(1);
        wait_valid("t2_w1", 1200);
        check("t2_data1", 32'(out_data), 32'hFFFF);
        check("t2_ch1", 32'(out_ch), 1);
        tick(1);
        wait_valid("t2_w2", 1200);
        check("t2_data2", 32'(out_data), 32'h2469);
        check("t2_ch2", 32'(out_ch), 0);
        check("t2_both_low", 32'(both_low), 0);

        pat[0] = 32'h5A5A_0000;
        do_reset(2'b01, 1'b0);
        wait_valid("t3_w0", 1200);
        check("t3_data0", 32'(out_data), 32'hB4B4);
        pat[0] = 32'h0000_0000;
        k = 0;
        while (!overrun && k < 1200) begin
            tick(1);
            k++;
        end
        check("t3_overrun_seen", 32'(overrun), 1);
        tick(5);
        check("t3_overrun_len", 32'(ovr_cnt), 1);
        check("t3_held_data", 32'(out_data), 32'hB4B4);
        check("t3_held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick(1);
        check("t3_valid_fall", 32'(out_valid), 0);

        pat[0] = 32'h5A5A_0000;
        do_reset(2'b01, 1'b1);
        wait_cs("t4_cs", 0, 50);
        tick(8 + 100);
        enable = 1'b0;
        wait_valid("t4_w0", 1200);
        check("t4_data", 32'(out_data), 32'hB4B4);
        check("t4_busy_gap", 32'(busy), 1);
        tick(70);
        check("t4_busy_idle", 32'(busy), 0);
        check("t4_cs_idle", 32'(cs_n), 32'h3);
        check("t4_sck_idle", 32'(sck), 1);
        tick(600);
        check("t4_no_restart", 32'(t_fall.size()), 1);

        pat[0] = 32'h1234_8000;
        do_reset(2'b11, 1'b1);
        wait_valid("t5_w0", 1200);
        check("t5_ch0", 32'(out_ch), 0);
        wait_cs("t5_cs1", 1, 700);
        tick(8 + 50);
        reset_n = 1'b0;
        #1;
        check("t5_async_cs", 32'(cs_n), 32'h3);
        check("t5_async_sck", 32'(sck), 1);
        check("t5_async_valid", 32'(out_valid), 0);
        check("t5_async_busy", 32'(busy), 0);
        tick(2);
        reset_n = 1'b1;
        wait_valid("t5_w1", 1200);
        check("t5_restart_ch", 32'(out_ch), 0);
        check("t5_restart_data", 32'(out_data), 32'h2469);

        pat[0] = 32'h5A5A_0000;
        do_reset(2'b01, 1'b1);
        wait_cs("t6_cs", 0, 50);
        tick(8 + 50);
        ch_mask = 2'b10;
        tick(1);
        check("t6_cs_hold", 32'(cs_n), 32'h2);
        wait_valid("t6_w0", 1200);
        check("t6_ch0", 32'(out_ch), 0);
        check("t6_data0", 32'(out_data), 32'hB4B4);
        tick(1);
        wait_valid("t6_w1", 1200);
        check("t6_ch1", 32'(out_ch), 1);
        check("t6_data1", 32'(out_data), 32'hFFFF);
        ch_mask = 2'b00;
        tick(100);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_cs", 32'(cs_n), 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
